// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RV32 pipeline.
//   Takes the ID/EX register outputs and produces the EX/MEM register contents.
//   Single-cycle ALU ops are registered in one clock. MUL, DIVU and REMU run on
//   an iterative unit for XLEN cycles, and upstream is held with stall_out.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_valid          a real instruction is presented (0 = bubble)
//   data_in_1/2       rs1 / rs2 values
//   imm_in, alusrc_in immediate and operand-B select (1 = immediate)
//   alu_op_in, rd_in  decoded operation and destination register
//   stall_out         upstream must hold ID/EX contents
//   result_out, rd_out, valid_out  registered result for EX/MEM
module ex_stage #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  data_in_1,
  input  logic [XLEN-1:0]  data_in_2,
  input  logic [XLEN-1:0]  imm_in,
  input  logic             alusrc_in,
  input  logic [3:0]       alu_op_in,
  input  logic [REG_W-1:0] rd_in,
  output logic             stall_out,
  output logic [XLEN-1:0]  result_out,
  output logic [REG_W-1:0] rd_out,
  output logic             valid_out
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [3:0]         op_q;
  logic [REG_W-1:0]   rd_q;

  // Shift-add multiplier: only the low XLEN bits of the product are kept.
  logic [XLEN-1:0]    mul_acc, mul_mcand, mul_mplier;

  // Restoring divider: {remainder, quotient} shift register and divisor.
  logic [2*XLEN-1:0]  div_rq;
  logic [XLEN-1:0]    div_b;
  logic [XLEN:0]      div_diff;
  logic               div_take;

  logic signed [XLEN-1:0] opb;
  logic               is_multi;

  function automatic logic [XLEN-1:0] alu(input logic [3:0] op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [4:0] shamt;
    logic [XLEN-1:0] r;
    shamt = b[4:0];
    r = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << shamt;
      4'd6: r = a >> shamt;
      4'd7: r = $unsigned($signed(a) >>> shamt);
      4'd8: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9: r = {{(XLEN-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign opb      = alusrc_in ? imm_in : data_in_2;
  assign is_multi = (alu_op_in == OP_MUL) || (alu_op_in == OP_DIVU) ||
                    (alu_op_in == OP_REMU);

  // The shifted partial remainder can reach 2*B-1, so compare with one extra
  // bit; the MSB of the difference is the borrow. A zero divisor always
  // "subtracts", yielding an all-ones quotient and a remainder equal to A.
  assign div_diff = div_rq[2*XLEN-1:XLEN-1] - {1'b0, div_b};
  assign div_take = ~div_diff[XLEN];

  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && is_multi) begin
          stall_out = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (count == CNT_W'(XLEN-1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- execute / iterate -> EX/MEM register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      div_rq     <= '0;
      div_b      <= '0;
      result_out <= '0;
      rd_out     <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && is_multi) begin
            count      <= '0;
            op_q       <= alu_op_in;
            rd_q       <= rd_in;
            mul_acc    <= '0;
            mul_mcand  <= data_in_1;
            mul_mplier <= opb;
            div_rq     <= {{XLEN{1'b0}}, data_in_1};
            div_b      <= opb;
          end else if (in_valid) begin
            result_out <= alu(alu_op_in, data_in_1, opb);
            rd_out     <= rd_in;
            valid_out  <= 1'b1;
          end
        end
        BUSY: begin
          count      <= count + 1'b1;
          if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          if (div_take) div_rq <= {div_diff[XLEN-1:0], div_rq[XLEN-2:0], 1'b1};
          else          div_rq <= {div_rq[2*XLEN-2:0], 1'b0};
        end
        DONE: begin
          case (op_q)
            OP_MUL:  result_out <= mul_acc;
            OP_DIVU: result_out <= div_rq[XLEN-1:0];
            default: result_out <= div_rq[2*XLEN-1:XLEN];
          endcase
          rd_out    <= rd_q;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
